// File: rtl/button_capture_pio_pkg.sv
// -----------------------------------------------------------------------------
// button_capture_pio_pkg
// Shared constants for the button/switch input PIO.
//   - Register word offsets. The layout matches the LED output PIO, so the
//     same HAL-style driver code can talk to either block.
//   - Edge-type selector values for the EDGE_TYPE parameter.
//   - A helper that sizes the debounce counter.
// -----------------------------------------------------------------------------
package button_capture_pio_pkg;

  // Word offsets on the 2-bit Avalon address bus
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Values for the EDGE_TYPE parameter
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Counter width for a debounce window of 'cycles' clocks.
  // The result is never below 1, so the counter declaration stays legal for
  // small windows.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// -----------------------------------------------------------------------------
// pio_debounce_bit
// Conditions a single asynchronous board input (button or switch):
//   two-flop synchroniser -> debouncer -> previous-state register.
// It reports the debounced level and single-cycle rise/fall pulses.
//
// Parameters
//   DEBOUNCE_CYCLES : the number of consecutive cycles the synchronised input
//                     must disagree with the debounced state before that
//                     state flips. 0 bypasses the filter entirely.
// Ports
//   clk     in  system clock
//   reset_n in  asynchronous, active-low reset
//   in_bit  in  raw asynchronous input
//   deb     out debounced level
//   rise    out one-cycle pulse on a debounced 0->1 transition
//   fall    out one-cycle pulse on a debounced 1->0 transition
// -----------------------------------------------------------------------------
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic deb,
  output logic rise,
  output logic fall
);

  import button_capture_pio_pkg::*;

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchroniser. in_bit has no relationship to clk, so nothing
  // downstream reads it before it has passed through both flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: the synchronised level is the debounced level
      assign deb = sync2;
    end else begin : g_filter
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          deb_q;

      // Debounce counter. It counts consecutive cycles in which the
      // synchronised input disagrees with the debounced state. Any cycle of
      // agreement restarts the count, so a glitch shorter than the window
      // never reaches CNT_LAST. The flip happens on the N-th disagreeing
      // cycle, at the same edge that would otherwise advance the count past
      // CNT_LAST. A reset in the middle of a window discards the partial
      // count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          deb_q <= 1'b0;
        end else if (sync2 == deb_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          deb_q <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign deb = deb_q;
    end
  endgenerate

  // Previous debounced level. Comparing it with deb gives a single-cycle
  // pulse for each debounced transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else begin
      prev <= deb;
    end
  end

  assign rise = deb & ~prev;
  assign fall = ~deb & prev;

endmodule

// File: rtl/button_capture_pio.sv
// -----------------------------------------------------------------------------
// button_capture_pio
// Avalon-MM slave input PIO, the read-side counterpart of the LED output PIO.
// Each input bit is synchronised and debounced. Selected debounced edges are
// latched into a sticky EDGECAPTURE register, and a maskable level interrupt
// is raised.
//
// Register map (word offsets)
//   0 DATA        : debounced input state (read-only; writes ignored)
//   1 DIRECTION   : always reads 0 (writes ignored)
//   2 IRQMASK     : read/write, bits [WIDTH-1:0]
//   3 EDGECAPTURE : read; writing 1 to a bit clears it
//
// Parameters
//   WIDTH           : number of inputs (1..32)
//   DEBOUNCE_CYCLES : debounce window in clocks, 0 = bypass
//   EDGE_TYPE       : 0 rising, 1 falling, 2 any
// Ports
//   clk, reset_n : clock and asynchronous active-low reset
//   address      : word offset
//   chipselect   : slave select
//   write_n      : active-low write strobe
//   writedata    : write data
//   in_port      : asynchronous board inputs
//   readdata     : zero-extended read data, combinational from address
//   irq          : active-high level interrupt
// -----------------------------------------------------------------------------
module button_capture_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  import button_capture_pio_pkg::*;

  logic [WIDTH-1:0] deb_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clear_vec;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic             write_en;

  assign write_en = chipselect && !write_n;

  // One conditioning chain per input bit
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bit  (in_port[i]),
        .deb     (deb_vec[i]),
        .rise    (rise_vec[i]),
        .fall    (fall_vec[i])
      );
    end

    // Only the low WIDTH bits of writedata are meaningful
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // Select which debounced transitions count as capture events. EDGE_TYPE is
  // a parameter, so only one branch survives synthesis.
  always_comb begin
    edge_vec = '0;
    if (EDGE_TYPE == EDGE_RISING) begin
      edge_vec = rise_vec;
    end else if (EDGE_TYPE == EDGE_FALLING) begin
      edge_vec = fall_vec;
    end else begin
      edge_vec = rise_vec | fall_vec;
    end
  end

  // Write-1-to-clear vector for EDGECAPTURE. It is non-zero only during a
  // qualified write to that offset.
  always_comb begin
    clear_vec = '0;
    if (write_en && (address == ADDR_EDGE)) begin
      clear_vec = writedata[WIDTH-1:0];
    end
  end

  // Interrupt mask register, written directly from the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (write_en && (address == ADDR_MASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky edge capture. The clear is applied before the new edges are OR-ed
  // in, so an edge that arrives in the same cycle as software clearing that
  // bit is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~clear_vec) | edge_vec;
    end
  end

  // The interrupt depends on register outputs only, so there is no
  // combinational path from the bus to irq.
  assign irq = |(edge_cap & irq_mask);

  // Zero-latency read mux. It needs no read strobe because reads have no
  // side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = deb_vec;
      ADDR_DIR:  readdata = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_button_capture_pio.sv
// -----------------------------------------------------------------------------
// tb_button_capture_pio
// Directed bench for button_capture_pio. It drives two instances:
//   dut   : WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 (falling)
//   dut_v : WIDTH=4, DEBOUNCE_CYCLES=0, EDGE_TYPE=2 (any edge, bypass)
// Inputs change on the falling edge of clk. The rising edge after a change is
// "edge 0". Outputs are sampled on the falling edge after the edge of
// interest.
// -----------------------------------------------------------------------------
module tb_button_capture_pio;

  import button_capture_pio_pkg::*;

  logic        clk;
  logic        reset_n;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic [1:0]  v_address;
  logic        v_chipselect;
  logic        v_write_n;
  logic [31:0] v_writedata;
  logic [3:0]  v_in_port;
  logic [31:0] v_readdata;
  logic        v_irq;

  int checks;
  int errors;

  button_capture_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  button_capture_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
  ) dut_v (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (v_address),
    .chipselect (v_chipselect),
    .write_n    (v_write_n),
    .writedata  (v_writedata),
    .in_port    (v_in_port),
    .readdata   (v_readdata),
    .irq        (v_irq)
  );

  // 100-unit clock period, which leaves room for several #1 reads per cycle
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Hard stop in case something stalls the stimulus thread
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: stimulus did not complete (actual=timeout required=finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value and record the result
  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock: active edge, then back to the sampling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive the board inputs of the selected instance
  task automatic apply_stimulus(input int unit, input logic [3:0] value);
    if (unit == 0) in_port = value;
    else           v_in_port = value;
  endtask

  // Read a register combinationally and compare all 32 bits, including the
  // zero upper bits
  task automatic check_reg(input int unit, input logic [1:0] addr,
                           input logic [31:0] expected, input string tag);
    logic [31:0] data;
    if (unit == 0) address = addr;
    else           v_address = addr;
    #1;
    data = (unit == 0) ? readdata : v_readdata;
    check_output(tag, data, expected);
  endtask

  // Single-cycle bus write. The write lands on the next rising edge.
  task automatic bus_write(input int unit, input logic [1:0] addr,
                           input logic [31:0] data, input logic cs);
    if (unit == 0) begin
      address = addr; writedata = data; chipselect = cs; write_n = 1'b0;
    end else begin
      v_address = addr; v_writedata = data; v_chipselect = cs; v_write_n = 1'b0;
    end
    tick();
    if (unit == 0) begin
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    end else begin
      v_chipselect = 1'b0; v_write_n = 1'b1; v_writedata = '0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    address = ADDR_DATA; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    v_address = ADDR_DATA; v_chipselect = 1'b0; v_write_n = 1'b1; v_writedata = '0;
    apply_stimulus(0, 4'hF);
    apply_stimulus(1, 4'h0);

    // Reset: all registers clear even with inputs held high
    repeat (3) @(negedge clk);
    check_reg(0, ADDR_DATA, 32'h0, "rst_data");
    check_reg(0, ADDR_MASK, 32'h0, "rst_mask");
    check_reg(0, ADDR_EDGE, 32'h0, "rst_edge");
    check_output("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;

    // The input held high through reset reaches DATA at edge 5
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 4) check_reg(0, ADDR_DATA, 32'h0, "data_edge4");
      if (k == 5) check_reg(0, ADDR_DATA, 32'hF, "data_edge5");
    end
    repeat (4) tick();
    check_reg(0, ADDR_EDGE, 32'h0, "rise_not_captured");
    check_output("rise_no_irq", {31'd0, irq}, 32'h0);

    // Falling edge on bit 2 with the mask written on edge 0
    apply_stimulus(0, 4'hB);
    bus_write(0, ADDR_MASK, 32'h4, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        check_reg(0, ADDR_DATA, 32'hB, "fall_data_edge5");
        check_reg(0, ADDR_EDGE, 32'h0, "fall_edge_edge5");
        check_output("fall_irq_edge5", {31'd0, irq}, 32'h0);
      end
      if (k == 6) begin
        check_reg(0, ADDR_EDGE, 32'h4, "fall_edge_edge6");
        check_output("fall_irq_edge6", {31'd0, irq}, 32'h1);
      end
    end
    check_reg(0, ADDR_MASK, 32'h4, "mask_readback");
    bus_write(0, ADDR_EDGE, 32'h4, 1'b1);
    check_reg(0, ADDR_EDGE, 32'h0, "w1c_clear");
    check_output("w1c_irq", {31'd0, irq}, 32'h0);

    // A 3-cycle glitch on bit 0 is rejected
    apply_stimulus(0, 4'hA);
    repeat (3) tick();
    apply_stimulus(0, 4'hB);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_reg(0, ADDR_DATA, 32'hB, "glitch_data");
    end
    check_reg(0, ADDR_EDGE, 32'h0, "glitch_edge");

    // A 4-cycle pulse on bit 0 is accepted and captured
    apply_stimulus(0, 4'hA);
    repeat (4) tick();
    apply_stimulus(0, 4'hB);
    for (int k = 4; k <= 6; k++) begin
      tick();
      if (k == 4) check_reg(0, ADDR_DATA, 32'hB, "pulse_data_edge4");
      if (k == 5) check_reg(0, ADDR_DATA, 32'hA, "pulse_data_edge5");
      if (k == 6) check_reg(0, ADDR_EDGE, 32'h1, "pulse_edge_edge6");
    end
    repeat (6) tick();
    check_reg(0, ADDR_DATA, 32'hB, "pulse_data_restored");
    check_reg(0, ADDR_EDGE, 32'h1, "pulse_edge_sticky");
    check_output("pulse_irq_masked", {31'd0, irq}, 32'h0);
    bus_write(0, ADDR_EDGE, 32'hF, 1'b1);
    check_reg(0, ADDR_EDGE, 32'h0, "pulse_clear");

    // Capture with the mask at zero, then unmask
    bus_write(0, ADDR_MASK, 32'h0, 1'b1);
    apply_stimulus(0, 4'h9);
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) check_reg(0, ADDR_EDGE, 32'h0, "mask0_edge5");
      if (k == 6) begin
        check_reg(0, ADDR_EDGE, 32'h2, "mask0_edge6");
        check_output("mask0_irq", {31'd0, irq}, 32'h0);
      end
    end
    bus_write(0, ADDR_MASK, 32'h2, 1'b1);
    check_output("unmask_irq", {31'd0, irq}, 32'h1);
    check_reg(0, ADDR_MASK, 32'h2, "unmask_readback");

    // Clearing bit 3 on the same edge it is captured leaves it set
    apply_stimulus(0, 4'h1);
    for (int k = 0; k <= 5; k++) tick();
    check_reg(0, ADDR_EDGE, 32'h2, "simul_before");
    bus_write(0, ADDR_EDGE, 32'h8, 1'b1);
    check_reg(0, ADDR_EDGE, 32'hA, "simul_set_wins");
    bus_write(0, ADDR_EDGE, 32'h8, 1'b1);
    check_reg(0, ADDR_EDGE, 32'h2, "simul_later_clear");

    // Bus decode: read-only offsets, chipselect qualifier, upper bits
    bus_write(0, ADDR_DATA, 32'hFFFF_FFFF, 1'b1);
    check_reg(0, ADDR_DATA, 32'h1, "wr_data_ignored");
    bus_write(0, ADDR_DIR, 32'hFFFF_FFFF, 1'b1);
    check_reg(0, ADDR_DIR, 32'h0, "dir_reads_zero");
    check_reg(0, ADDR_MASK, 32'h2, "dir_wr_mask_kept");
    check_reg(0, ADDR_EDGE, 32'h2, "dir_wr_edge_kept");
    bus_write(0, ADDR_MASK, 32'hF, 1'b0);
    check_reg(0, ADDR_MASK, 32'h2, "nocs_mask_kept");
    bus_write(0, ADDR_EDGE, 32'hF, 1'b0);
    check_reg(0, ADDR_EDGE, 32'h2, "nocs_edge_kept");
    bus_write(0, ADDR_MASK, 32'hFFFF_FFF5, 1'b1);
    check_reg(0, ADDR_MASK, 32'h5, "mask_upper_dropped");
    check_output("mask5_irq", {31'd0, irq}, 32'h0);

    // Bypass variant with any-edge capture on bit 3
    bus_write(1, ADDR_MASK, 32'h8, 1'b1);
    apply_stimulus(1, 4'h8);
    for (int k = 0; k <= 2; k++) begin
      tick();
      if (k == 0) check_reg(1, ADDR_DATA, 32'h0, "v_rise_data_edge0");
      if (k == 1) begin
        check_reg(1, ADDR_DATA, 32'h8, "v_rise_data_edge1");
        check_reg(1, ADDR_EDGE, 32'h0, "v_rise_edge_edge1");
        check_output("v_rise_irq_edge1", {31'd0, v_irq}, 32'h0);
      end
      if (k == 2) begin
        check_reg(1, ADDR_EDGE, 32'h8, "v_rise_edge_edge2");
        check_output("v_rise_irq_edge2", {31'd0, v_irq}, 32'h1);
      end
    end
    bus_write(1, ADDR_EDGE, 32'h8, 1'b1);
    check_reg(1, ADDR_EDGE, 32'h0, "v_clear");
    check_output("v_clear_irq", {31'd0, v_irq}, 32'h0);
    apply_stimulus(1, 4'h0);
    for (int k = 0; k <= 2; k++) begin
      tick();
      if (k == 1) begin
        check_reg(1, ADDR_DATA, 32'h0, "v_fall_data_edge1");
        check_reg(1, ADDR_EDGE, 32'h0, "v_fall_edge_edge1");
      end
      if (k == 2) begin
        check_reg(1, ADDR_EDGE, 32'h8, "v_fall_edge_edge2");
        check_output("v_fall_irq_edge2", {31'd0, v_irq}, 32'h1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_capture_pio.md
# button_capture_pio

Avalon-MM slave input PIO: the read-side counterpart to the memory-mapped LED output port. It samples WIDTH asynchronous board inputs (push-buttons, slide switches), synchronises and debounces them, latches selected edges into a sticky capture register, and raises a maskable level interrupt to the Nios II. Register map and bus timing match the existing output PIOs, so the same HAL-style driver code applies.

## Interface
Parameters:
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, cycles an input must differ stably before the debounced state flips; 0 = bypass
- EDGE_TYPE, 1, captured edge: 0 rising, 1 falling, 2 any

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  word register offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  read data, zero-extended
- irq  out  1  level interrupt, active-high

## Operation
- Clock: clk. Reset: reset_n, asynchronous, active-low.
- Register map:
  - 0 DATA: read-only debounced state; writes ignored.
  - 1 DIRECTION: reads 0; writes ignored.
  - 2 IRQMASK: read/write; writedata[WIDTH-1:0].
  - 3 EDGECAPTURE: read; write-1-to-clear per bit.
- Write qualifier: chipselect && !write_n.
- Read qualifier: none. readdata is driven combinationally from address at all times, with read latency 0. Bits 31:WIDTH are always 0.
- Per bit, in order:
  - two-flop synchroniser (sync1, sync2);
  - debouncer;
  - previous-state register prev;
  - edge detector;
  - capture flop.
- Debouncer: holds deb and counter cnt (width clog2(DEBOUNCE_CYCLES+1)).
  - If sync2 == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
  - DEBOUNCE_CYCLES=0: deb is a wire equal to sync2, and no counter is instantiated.
- Edge detection:
  - rise = deb & ~prev
  - fall = ~deb & prev
  - edge selected by EDGE_TYPE
- EDGECAPTURE bit: set on edge. Cleared by a write to offset 3 with writedata bit = 1. If set and clear occur in the same cycle, set wins.
- irq = |(EDGECAPTURE & IRQMASK), taken from registers only, with no combinational path from the bus.
- Reset values: sync, deb, prev, cnt, IRQMASK and EDGECAPTURE are all 0, so irq=0 and readdata=0 at address 0.
- An input held high through reset produces one rising edge after synchronisation and debounce. This is intended; software clears it at init.
- Reset mid-debounce discards the count.

## Timing
- in_port change settles before edge 0; sync1 updates at edge 0 and sync2 at edge 1.
- Bypass (DEBOUNCE_CYCLES=0): DATA shows the new value after edge 1. EDGECAPTURE sets and irq asserts after edge 2.
- DEBOUNCE_CYCLES=N≥1: deb flips at edge 1+N, provided the input is stable for the whole window. EDGECAPTURE and irq follow at edge 2+N.
- IRQMASK or EDGECAPTURE write at edge k: register and irq update after edge k. A readback in cycle k+1 shows the new value.
- irq deasserts in the cycle after the clearing write, unless a new edge lands on that same edge.

## Structure
- Package button_capture_pio_pkg holds:
  - register offsets ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY constants.
- Sub-module pio_debounce_bit: synchroniser, debouncer and prev register for one bit. It has parameter DEBOUNCE_CYCLES and outputs deb, rise and fall. It is instantiated WIDTH times in a generate loop.
- Top level contains the bus decode, IRQMASK, EDGECAPTURE, readdata mux and irq.

## Test plan
Bench uses WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless noted.
- Reset: after reset with in_port=4'hF, reads at offsets 0/2/3 → 0/0/0 and irq=0. Rising edges are not captured (EDGE_TYPE=1), and DATA reads 4'hF after edge 5.
- Falling edge: starting from in_port=4'hF, drive bit 2 low and hold it; write IRQMASK=4'h4. Expect EDGECAPTURE=4'h4 and irq=1 exactly at edge 6. Write 4'h4 to offset 3 → EDGECAPTURE=0 and irq=0 next cycle.
- Glitch rejection: pulse bit 0 low for 3 cycles → DATA never changes and EDGECAPTURE stays 0. A 4-cycle low pulse → DATA bit 0 toggles and a capture occurs.
- Masking and simultaneity: IRQMASK=0 with an edge on bit 1 → EDGECAPTURE=4'h2 and irq=0. Setting mask 4'h2 gives irq=1 next cycle. A clear written on the same edge as a new capture leaves the bit set.
- Bus decode: a write to offset 0 or 1 changes nothing. A write with chipselect=0 is ignored. A read of offset 1 returns 0. readdata[31:4] is always 0.
- Variants: DEBOUNCE_CYCLES=0 with EDGE_TYPE=2 → a toggle of bit 3 captures at edge 2 for both directions.
